// File: rtl/framebuffer_swap.sv
// framebuffer_swap: double-buffered 1-bit-per-pixel framebuffer.
// The renderer writes into the back bank while scanout reads the front bank.
// A frame_end pulse exchanges the banks and answers with a one-ce-cycle swap.
// Optional feature macro FRAMEBUFFER_SWAP_CLEAR_EN: when defined, the new back
// bank is zeroed (one address per ce cycle) before swap is issued. While that
// clear runs, renderer writes are dropped and further frame_end pulses are ignored.
module framebuffer_swap #(
    parameter int HOR_ACTIVE_PIXELS = 4,
    parameter int VER_ACTIVE_PIXELS = 2,
    localparam int DEPTH      = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_data,
    input  logic                  frame_end,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data,
    output logic                  swap,
    output logic                  wr_drop
);

    // One extra bit so the range check also works when DEPTH is a power of two
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic bank0 [DEPTH];
    logic bank1 [DEPTH];

    logic                  front;
    logic                  in_clear;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_accept;
    logic                  bank_we;
    logic [ADDR_WIDTH-1:0] bank_wa;
    logic                  bank_wd;

`ifdef FRAMEBUFFER_SWAP_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    logic [ADDR_WIDTH-1:0] clr_addr;
`else
    typedef enum logic {IDLE} state_t;
`endif
    state_t state;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;

`ifdef FRAMEBUFFER_SWAP_CLEAR_EN
    assign in_clear = (state == CLEAR);
`else
    assign in_clear = 1'b0;
`endif

    // A renderer write lands only if it is in range and no clear is running
    assign wr_accept = wr_en && wr_in_range && !in_clear;

    // Pick the single write source for the back bank: clear sweep or renderer
    always_comb begin
        bank_we = ce && wr_accept;
        bank_wa = wr_addr;
        bank_wd = wr_data;
`ifdef FRAMEBUFFER_SWAP_CLEAR_EN
        if (in_clear) begin
            bank_we = ce;
            bank_wa = clr_addr;
            bank_wd = 1'b0;
        end
`endif
    end

    // RAM write ports; contents are deliberately not reset, and only the back bank is written
    always_ff @(posedge clk) begin
        if (bank_we) begin
            if (front) begin
                bank0[bank_wa] <= bank_wd;
            end else begin
                bank1[bank_wa] <= bank_wd;
            end
        end
    end

    // Control FSM: bank select, swap pulse, drop flag, clear sweep and registered scanout read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front   <= 1'b0;
            rd_data <= 1'b0;
            swap    <= 1'b0;
            wr_drop <= 1'b0;
            state   <= IDLE;
`ifdef FRAMEBUFFER_SWAP_CLEAR_EN
            clr_addr <= '0;
`endif
        end else if (ce) begin
            // Bank select uses front as it stands in the cycle the address is presented
            if (rd_in_range) begin
                rd_data <= front ? bank1[rd_addr] : bank0[rd_addr];
            end else begin
                rd_data <= 1'b0;
            end

            swap <= 1'b0;

            if (wr_en && !wr_accept) begin
                wr_drop <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_end) begin
                        front <= !front;
`ifdef FRAMEBUFFER_SWAP_CLEAR_EN
                        state <= CLEAR;
`else
                        swap  <= 1'b1;
`endif
                    end
                end
`ifdef FRAMEBUFFER_SWAP_CLEAR_EN
                CLEAR: begin
                    // frame_end is ignored here; the sweep always runs to the end
                    if (clr_addr == LAST_ADDR) begin
                        clr_addr <= '0;
                        state    <= IDLE;
                        swap     <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + ADDR_WIDTH'(1);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_swap.sv
// Scoreboard bench for framebuffer_swap on a 3x3 (DEPTH=9) frame.
// Stimulus pushes expected read results and expected swap ce-cycle indices;
// a negedge monitor pops and compares whenever a read result or swap edge appears.
// Works for both builds (FRAMEBUFFER_SWAP_CLEAR_EN defined or not).
module tb_framebuffer_swap;

    localparam int W     = 3;
    localparam int H     = 3;
    localparam int DEPTH = W * H;
    localparam int AW    = $clog2(DEPTH);
`ifdef FRAMEBUFFER_SWAP_CLEAR_EN
    localparam int LAT = DEPTH + 1;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          ce;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          frame_end;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          swap;
    logic          wr_drop;

    typedef struct {
        int addr;
        int rd;
        int drop;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      sw_q[$];

    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   ce_cnt    = 0;
    int   rise_at   = 0;
    logic rd_req    = 1'b0;
    logic rd_chk    = 1'b0;
    logic swap_prev = 1'b0;
    bit   ce_toggle = 1'b0;

    framebuffer_swap #(
        .HOR_ACTIVE_PIXELS(W),
        .VER_ACTIVE_PIXELS(H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_end(frame_end),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .swap     (swap),
        .wr_drop  (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed ce cycles and mark the cycle in which a checked read result appears
    always @(posedge clk) begin
        if (ce) ce_cnt <= ce_cnt + 1;
        rd_chk <= ce && rd_req;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a read result or a swap edge
    always @(negedge clk) begin
        rd_exp_t x;
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                x = rd_q.pop_front();
                chk($sformatf("rd_data[%0d]", x.addr), int'(rd_data), x.rd);
                chk($sformatf("wr_drop@rd[%0d]", x.addr), int'(wr_drop), x.drop);
            end
        end
        if (rst) begin
            if (swap && !swap_prev) begin
                if (sw_q.size() == 0) begin
                    chk("swap_unexpected", 1, 0);
                end else begin
                    rise_at = sw_q.pop_front();
                    chk("swap_rise_cecycle", ce_cnt, rise_at);
                end
            end
            if (!swap && swap_prev) begin
                chk("swap_fall_cecycle", ce_cnt, rise_at + 1);
            end
        end
        swap_prev = swap;
    end

    // Advance one ce cycle; in toggle mode a ce=0 cycle follows every active one
    task automatic tick();
        ce = 1'b1;
        @(posedge clk); #1;
        if (ce_toggle) begin
            ce = 1'b0;
            @(posedge clk); #1;
            ce = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d[0];
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input int a, input int e, input int drop);
        rd_exp_t x;
        x.addr = a;
        x.rd   = e;
        x.drop = drop;
        rd_q.push_back(x);
        rd_addr = AW'(a);
        rd_req  = 1'b1;
        tick();
        rd_req  = 1'b0;
    endtask

    task automatic fe(input bit expect_swap);
        frame_end = 1'b1;
        if (expect_swap) sw_q.push_back(ce_cnt + LAT);
        tick();
        frame_end = 1'b0;
    endtask

    task automatic fe_wr(input int a, input int d);
        frame_end = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = AW'(a);
        wr_data   = d[0];
        sw_q.push_back(ce_cnt + LAT);
        tick();
        frame_end = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rd_data"}, int'(rd_data), 0);
        chk({tag, "_swap"}, int'(swap), 0);
        chk({tag, "_wr_drop"}, int'(wr_drop), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; ce = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0;
        frame_end = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b1;

        // Fill back bank1 with odd=1, swap it to the front
        for (int i = 0; i < DEPTH; i++) wr(i, i % 2);
        fe(1'b1);
        idle(LAT + 1);
        rd(3, 1, 0);
        rd(4, 0, 0);
        rd(8, 0, 0);
        rd(7, 1, 0);
        rd(0, 0, 0);

        // Fill back bank0 with even=1; write addr1 in the same cycle as frame_end
        for (int i = 0; i < DEPTH; i++) wr(i, (i + 1) % 2);
        rd(1, 1, 0);
        fe_wr(1, 1);
        rd(1, 1, 0);
        idle(LAT + 1);
        rd(0, 1, 0);
        rd(3, 0, 0);
        rd(8, 1, 0);
        rd(2, 1, 0);

        // ce toggling: bank1 gets only addr5=1, out-of-range writes set the drop flag
        ce_toggle = 1'b1;
        for (int i = 0; i < DEPTH; i++) wr(i, (i == 5) ? 1 : 0);
        wr(9, 1);
        wr(15, 1);
        rd(2, 1, 1);
        fe(1'b1);
        idle(LAT + 1);
        for (int i = 0; i < DEPTH; i++) rd(i, (i == 5) ? 1 : 0, 1);
        ce_toggle = 1'b0;

        // Reset returns front to bank0 (addr5 is 0 there, 1 in bank1) and clears wr_drop
        do_reset();
        chk_reset_state("reset2");
        rd(5, 0, 0);

`ifdef FRAMEBUFFER_SWAP_CLEAR_EN
        // Bank1 all ones; during the clear a write at N+3 is dropped and frame_end at N+4 ignored
        for (int i = 0; i < DEPTH; i++) wr(i, 1);
        fe(1'b1);
        idle(2);
        wr(0, 1);
        fe(1'b0);
        rd(4, 1, 1);
        idle(6);
        // Second swap shows bank0: fully zeroed, dropped write absent
        fe(1'b1);
        idle(LAT + 1);
        for (int i = 0; i < DEPTH; i++) rd(i, 0, 1);

        // Reset in the middle of a clear: no swap, front back to bank0, FSM idle
        for (int i = 0; i < DEPTH; i++) wr(i, 1);
        fe(1'b0);
        idle(3);
        do_reset();
        chk_reset_state("reset_mid_clear");
        wr(6, 0);
        idle(LAT + 2);
        rd(3, 0, 0);
`else
        // Without the clear, a write right after frame_end is accepted into the new back bank
        fe(1'b1);
        wr(5, 0);
        idle(2);
        fe(1'b1);
        idle(2);
        rd(5, 0, 0);
        rd(4, 1, 0);
`endif

        idle(4);
        chk("swap_q_left", sw_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
